// File: rtl/diff_line_pkg.sv
// -----------------------------------------------------------------------------
// diff_line_pkg
// Definitions shared by the differential (XOR) line encoder and decoder:
//   line_state_e  : framer state, HUNT (searching for sync) or DATA (in a frame)
//   SYNC_W        : width of the sync pattern, in bits
//   SYNC_DEFAULT  : default sync pattern
// -----------------------------------------------------------------------------
package diff_line_pkg;

    localparam int SYNC_W = 8;

    localparam logic [SYNC_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        DATA = 1'b1
    } line_state_e;

endpackage : diff_line_pkg

// File: rtl/diff_bit_decoder.sv
// -----------------------------------------------------------------------------
// diff_bit_decoder
// Recovers data bits from an XOR-encoded line. The encoder drives
// q <= q ^ d while enabled and clears q to 0 while disabled, so the data
// bit is the XOR of the current and previous line bits.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   en        : line enable, aligned with q_in
//   q_in      : encoded line bit
//   bit_data  : recovered bit (combinational, for use on the same edge)
//   bit_valid : bit_data carries a bit this cycle
// -----------------------------------------------------------------------------
module diff_bit_decoder (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic q_in,
    output logic bit_data,
    output logic bit_valid
);

    logic prev_r;

    // Previous line bit; follows the encoder's clear-to-0 while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else if (en) begin
            prev_r <= q_in;
        end else begin
            prev_r <= 1'b0;
        end
    end

    // Bit recovery; the top module registers everything derived from it.
    always_comb begin
        bit_data  = q_in ^ prev_r;
        bit_valid = en;
    end

endmodule : diff_bit_decoder

// File: rtl/diff_stream_decoder.sv
// -----------------------------------------------------------------------------
// diff_stream_decoder
// Decodes an XOR-encoded serial line, hunts for a sync pattern and then
// deserializes FRAME_WORDS words of WIDTH bits (MSB first) into a single-entry
// valid/ready output register.
// Parameters:
//   WIDTH       : bits per output word (>= 2)
//   SYNC        : sync pattern matched against the last SYNC_W decoded bits
//   FRAME_WORDS : words per frame after sync, 1..255
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   en, q_in    : line enable and encoded line bit
//   out_data    : decoded word
//   out_valid   : out_data holds an unconsumed word
//   out_ready   : consumer accepts the word when out_valid && out_ready
//   out_last    : out_data is the last word of its frame
//   locked      : high while inside a frame (DATA state)
//   overrun     : sticky, a completed word was dropped; cleared only by rst
// -----------------------------------------------------------------------------
module diff_stream_decoder
    import diff_line_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter logic [SYNC_W-1:0] SYNC        = SYNC_DEFAULT,
    parameter int                FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             locked,
    output logic             overrun
);

    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WCNT_W = 8;

    line_state_e       state_r;
    // Only SYNC_W-1 history bits are stored: the newest bit completes the
    // window combinationally, which is all the match needs.
    logic [SYNC_W-2:0] window_r;
    logic [WIDTH-2:0]  shreg_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [WCNT_W-1:0] word_cnt_r;

    logic              bit_data_s;
    logic              bit_valid_s;
    logic [SYNC_W-1:0] window_next_s;
    logic [WIDTH-1:0]  word_s;
    logic              sync_hit_s;
    logic              word_done_s;
    logic              last_word_s;
    logic              slot_free_s;

    diff_bit_decoder u_bit_decoder (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .q_in      (q_in),
        .bit_data  (bit_data_s),
        .bit_valid (bit_valid_s)
    );

    // Next-window, completed-word and output-slot decisions for this edge.
    always_comb begin
        window_next_s = {window_r, bit_data_s};
        word_s        = {shreg_r, bit_data_s};
        sync_hit_s    = (window_next_s == SYNC);
        last_word_s   = (word_cnt_r == WCNT_W'(FRAME_WORDS - 1));
        slot_free_s   = (!out_valid) || out_ready;
        if (bit_valid_s && (state_r == DATA) && (bit_cnt_r == CNT_W'(WIDTH - 1))) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Framing FSM: sync hunt, bit/word counting and the locked flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= HUNT;
            window_r   <= {(SYNC_W-1){1'b0}};
            shreg_r    <= {(WIDTH-1){1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            word_cnt_r <= {WCNT_W{1'b0}};
            locked     <= 1'b0;
        end else if (!bit_valid_s) begin
            // Line disabled: abort any frame, partial word is discarded.
            state_r    <= HUNT;
            window_r   <= {(SYNC_W-1){1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            word_cnt_r <= {WCNT_W{1'b0}};
            locked     <= 1'b0;
        end else begin
            case (state_r)
                HUNT: begin
                    if (sync_hit_s) begin
                        state_r    <= DATA;
                        window_r   <= {(SYNC_W-1){1'b0}};
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        word_cnt_r <= {WCNT_W{1'b0}};
                        locked     <= 1'b1;
                    end else begin
                        window_r <= window_next_s[SYNC_W-2:0];
                    end
                end
                DATA: begin
                    shreg_r <= word_s[WIDTH-2:0];
                    if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        if (last_word_s) begin
                            // Frame complete; the next sync must arrive in full.
                            state_r    <= HUNT;
                            window_r   <= {(SYNC_W-1){1'b0}};
                            word_cnt_r <= {WCNT_W{1'b0}};
                            locked     <= 1'b0;
                        end else begin
                            word_cnt_r <= word_cnt_r + WCNT_W'(1);
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= HUNT;
                    window_r <= {(SYNC_W-1){1'b0}};
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry output register with drop-on-full and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else if (word_done_s) begin
            // A consume in the same cycle frees the slot for the new word.
            if (slot_free_s) begin
                out_data  <= word_s;
                out_last  <= last_word_s;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule : diff_stream_decoder

// File: doc/diff_stream_decoder.md
# diff_stream_decoder

Receive-side counterpart of the team's XOR (differential) bit encoder, in which the encoder's line bit updates as q <= q ^ d while enabled and clears to 0 while disabled. This block recovers each data bit as the XOR of consecutive line bits, hunts for a sync pattern, and deserializes a fixed-length frame of words. Each word is presented on a valid/ready output port for the downstream consumer.

## Interface
Parameters:
- WIDTH, 8, bits per output word.
- SYNC, 8'hA5, 8-bit sync pattern, compared against the last 8 decoded bits.
- FRAME_WORDS, 4, words per frame after sync, range 1..255.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  line enable, aligned with q_in; 0 means the encoder is held in reset.
- q_in  input  1  encoded line bit.
- out_data  output  WIDTH  decoded word, MSB first on the line.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_last  output  1  qualifies out_data as the final word of the frame.
- locked  output  1  high while in DATA state.
- overrun  output  1  sticky; a completed word was dropped. Cleared only by rst.

## Operation
- Bit recovery, on edges with en=1:
  - bit = q_in ^ prev, then prev <= q_in.
  - en=0: prev <= 0, matching the encoder's clear to 0. No bit is produced.
- State machine, two states; reset state is HUNT.
  - HUNT: shift bit into an 8-bit window (LSB in). Move to DATA on the edge where the updated window equals SYNC. At that edge, clear the bit counter and word counter.
  - DATA: shift bit into a WIDTH-bit shift register.
    - When WIDTH bits are collected, the word completes.
    - After word number FRAME_WORDS completes, return to HUNT and clear the window to 0.
- Output register, single entry:
  - A completed word loads out_data and out_last and sets out_valid.
  - The slot is free if out_valid=0, or if out_ready=1 in the same cycle. Consume and load in one cycle is allowed and is not a drop.
  - If the slot is not free, drop the new word and set overrun. The word counter still advances.
  - A handshake with no new word clears out_valid.
- en=0 during DATA:
  - Abort the frame and discard the partial word.
  - Go to HUNT and clear the window and counters.
  - A word already in the output register is kept until consumed.
- en=0 during HUNT: clear the window.
- Reset values: out_data=0, out_valid=0, out_last=0, locked=0, overrun=0, prev=0, state=HUNT, window=0.
- rst overrides all other inputs on the same edge, including mid-frame. Any held word is lost.

## Timing
- Decode latency:
  - Last bit of a word is sampled at edge k; out_valid=1 and the word are visible from edge k up to edge k+1.
  - No combinational path from q_in, en or out_ready to any output.
- Lock:
  - locked rises on the edge that samples the last sync bit.
  - The first data bit is the next enabled sample.
  - locked falls on the edge completing the last word, or on en=0 / rst.
- Idle cycles: an en=1 cycle always carries a bit, and there are no stall cycles inside a frame. The consumer must drain each word within WIDTH cycles or overrun is set.
- Back-to-back frames: HUNT restarts on the next bit, and the next frame's sync must fully reappear. Data bits never count toward the next sync.

## Structure
- Shared package diff_line_pkg contains:
  - the state enum {HUNT, DATA};
  - the default SYNC constant;
  - an 8-bit sync width constant, for reuse by the encoder-side framer.
- One sub-module: diff_bit_decoder.
  - Holds the prev register and the XOR.
  - Outputs bit and bit_valid.
- The FSM, counters and output register stay in the top module.

## Test plan
The bench drives q_in through a reference encoder model: q <= q ^ d when en, else 0.
- Basic frame, out_ready=1: decoded bits A5, 12, 34, 56, 78 (MSB first).
  - Required: four handshakes with out_data 12, 34, 56, 78.
  - out_last only on 78.
  - Each out_valid is asserted from the edge sampling the word's last bit.
- Backpressure:
  - out_ready=0 through the 12 and 34 words: 12 is held, 34 is dropped, overrun=1. Then raising out_ready for the rest of the frame yields 12, 56, 78.
  - Consume-and-load in the same cycle: overrun stays 0.
- False sync: decoded bits 5A, A4, then A5, 01, 02, 03, 04.
  - Required: lock only after A5; words are 01..04.
- en drop mid-word: en=0 for 2 cycles after 3 bits of word 2.
  - Required: locked falls and the partial word is discarded; the already-held word 1 still completes its handshake.
  - A fresh A5 frame then decodes correctly from prev=0.
- Reset mid-frame: assert rst with out_valid=1.
  - Required: all outputs 0 on the next edge, overrun cleared, and a subsequent frame decodes normally.
- FRAME_WORDS=1, WIDTH=16: bits A5, BEEF.
  - Required: a single word BEEF with out_last=1, then a return to HUNT.
